// File: rtl/tone_pkg.sv
// tone_pkg: shared width helpers and reset constants for the poly_tone_gen block.
// No ports. Provides:
//   mix_w_f(vol_w, channels) - mix width, wide enough for every channel at full volume
//   chan_w_f(channels)       - channel index width, at least 1 bit
//   CHAN_RST_BIT             - fill bit for the reset value of the channel record
package tone_pkg;

    function automatic int mix_w_f(input int vol_w, input int channels);
        return vol_w + $clog2(channels + 1);
    endfunction

    function automatic int chan_w_f(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    localparam logic CHAN_RST_BIT = 1'b0;

endpackage

// File: rtl/tone_channel.sv
// tone_channel: one square-wave tone voice with its programmable period, volume and gate.
// Ports:
//   clk, resetn         - clock, asynchronous active-low reset
//   wr_en               - load wr_period/wr_vol/wr_gate together on this edge
//   wr_period           - half-period in clk cycles (0 silences the voice)
//   wr_vol, wr_gate     - voice volume and gate
//   phase               - current square-wave level
//   vol                 - registered volume, fed to the mixer
//   active              - gate & (period != 0)
module tone_channel
    import tone_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int VOL_W    = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [VOL_W-1:0]    wr_vol,
    input  logic                wr_gate,
    output logic                phase,
    output logic [VOL_W-1:0]    vol,
    output logic                active
);

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic [VOL_W-1:0]    vol;
        logic                gate;
        logic [PERIOD_W-1:0] cnt;
        logic                phase;
    } chan_t;

    localparam chan_t CHAN_RST = {$bits(chan_t){CHAN_RST_BIT}};

    chan_t chan_q, chan_d;

    // The countdown always works from the pre-write register values, so a
    // write landing on a reload edge only takes effect at the next reload.
    always_comb begin
        chan_d = chan_q;
        if (wr_en) begin
            chan_d.period = wr_period;
            chan_d.vol    = wr_vol;
            chan_d.gate   = wr_gate;
        end
        if (!chan_q.gate || chan_q.period == '0) begin
            chan_d.cnt   = '0;
            chan_d.phase = 1'b0;
        end else if (chan_q.cnt == '0) begin
            chan_d.cnt   = chan_q.period - PERIOD_W'(1);
            chan_d.phase = ~chan_q.phase;
        end else begin
            chan_d.cnt   = chan_q.cnt - PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) chan_q <= CHAN_RST;
        else         chan_q <= chan_d;
    end

    assign phase  = chan_q.phase;
    assign vol    = chan_q.vol;
    assign active = chan_q.gate && (chan_q.period != '0);

endmodule

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: polyphonic square-wave tone generator with PCM mix and 1-bit sigma-delta output.
// Ports:
//   clk, resetn                    - clock, asynchronous active-low reset
//   wr_en, wr_chan                 - write strobe and target channel (>= CHANNELS ignored)
//   wr_period, wr_vol, wr_gate     - channel settings, loaded together
//   active                         - per-channel gate & (period != 0)
//   mix                            - registered sum of sounding channel volumes
//   speaker                        - sigma-delta bitstream of mix
module poly_tone_gen
    import tone_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int PERIOD_W = 32,
    parameter  int VOL_W    = 4,
    localparam int MIX_W    = mix_w_f(VOL_W, CHANNELS),
    localparam int CHAN_W   = chan_w_f(CHANNELS)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [VOL_W-1:0]    wr_vol,
    input  logic                wr_gate,
    output logic [CHANNELS-1:0] active,
    output logic [MIX_W-1:0]    mix,
    output logic                speaker
);

    logic [CHANNELS-1:0] chan_we;
    logic [CHANNELS-1:0] phase;
    logic [VOL_W-1:0]    vol [CHANNELS];
    logic [MIX_W-1:0]    mix_d, mix_q, acc_d, acc_q;
    logic                speaker_d, speaker_q;

    // Out-of-range indices never match any channel, so such writes are dropped.
    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            assign chan_we[i] = wr_en && (wr_chan == CHAN_W'(i));
            tone_channel #(
                .PERIOD_W (PERIOD_W),
                .VOL_W    (VOL_W)
            ) u_ch (
                .clk       (clk),
                .resetn    (resetn),
                .wr_en     (chan_we[i]),
                .wr_period (wr_period),
                .wr_vol    (wr_vol),
                .wr_gate   (wr_gate),
                .phase     (phase[i]),
                .vol       (vol[i]),
                .active    (active[i])
            );
        end
    endgenerate

    // Full-width sum cannot overflow; the accumulator carry is the output bit,
    // giving a ones density of mix / 2^MIX_W.
    always_comb begin
        mix_d = '0;
        for (int c = 0; c < CHANNELS; c++)
            mix_d = mix_d + (phase[c] ? MIX_W'(vol[c]) : MIX_W'(0));
        {speaker_d, acc_d} = {1'b0, acc_q} + {1'b0, mix_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mix_q     <= '0;
            acc_q     <= '0;
            speaker_q <= 1'b0;
        end else begin
            mix_q     <= mix_d;
            acc_q     <= acc_d;
            speaker_q <= speaker_d;
        end
    end

    assign mix     = mix_q;
    assign speaker = speaker_q;

endmodule
